irq_ctrl_prio_apb: RTL and testbench

- Parametrised successor to the team's 4-line APB interrupt controller.
- NUM_IRQ sources, each with a software-programmable priority and enable.
- A global priority threshold gates which sources may interrupt; a claim/complete handshake serves one interrupt at a time.
- Sits on the peripheral APB bus; drives a single CPU interrupt line plus the winning source ID.

---
 rtl/irq_ctrl_prio_apb_if.sv | 22 ++
 rtl/irq_ctrl_prio_apb.sv | 203 ++++++++++++++++++++
 tb/tb_irq_ctrl_prio_apb.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_prio_apb_if.sv
// APB slave bus bundle for irq_ctrl_prio_apb.
// The master modport drives requests and the slave modport returns read data and status.
interface irq_ctrl_prio_apb_if;
   logic        psel_i;
   logic        penable_i;
   logic        pwrite_i;
   logic [31:0] paddr_i;
   logic [31:0] pwdata_i;
   logic [31:0] prdata_o;
   logic        pready_o;
   logic        pslverr_o;

   modport master (
      output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
      input  prdata_o, pready_o, pslverr_o
   );

   modport slave (
      input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
      output prdata_o, pready_o, pslverr_o
   );
endinterface

// File: rtl/irq_ctrl_prio_apb.sv
// Prioritised APB interrupt controller with threshold gating and a claim/complete handshake.
// Defining IRQC_EDGE_MODE_EN adds the EDGE register and per-source rising-edge capture.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | nothing presented; waiting for an eligible source
// ST_ASSERT  | interrupt_o high, irq_id_o tracks the current winner
// ST_SERVICE | source claimed; waiting for a matching COMPLETE write
module irq_ctrl_prio_apb #(
   parameter int  NUM_IRQ = 8,
   parameter int  PRIO_W  = 3,
   localparam int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic               pclk_i,
   input  logic               rst_n_i,
   input  logic               enable_i,
   irq_ctrl_prio_apb_if.slave apb,
   input  logic [NUM_IRQ-1:0] irq_trigger_i,
   output logic               interrupt_o,
   output logic [ID_W-1:0]    irq_id_o
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ASSERT  = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   localparam logic [9:0] IDX_ENABLE   = 10'd0;
   localparam logic [9:0] IDX_PENDING  = 10'd1;
   localparam logic [9:0] IDX_THRESH   = 10'd2;
   localparam logic [9:0] IDX_CLAIM    = 10'd3;
   localparam logic [9:0] IDX_EDGE     = 10'd4;
   localparam logic [9:0] IDX_PRIO     = 10'd8;
   localparam logic [9:0] IDX_PRIO_END = 10'(8 + NUM_IRQ);

   logic [1:0]         state_q;
   logic [NUM_IRQ-1:0] enable_q;
   logic [NUM_IRQ-1:0] pending_q;
   logic [NUM_IRQ-1:0] pending_d;
   logic [NUM_IRQ-1:0] claim_clr;
   logic [NUM_IRQ-1:0] set_src;
   logic [NUM_IRQ-1:0] edge_rd;
   logic [NUM_IRQ-1:0] eligible;
   logic [PRIO_W-1:0]  thresh_q;
   logic [PRIO_W-1:0]  win_prio;
   logic [PRIO_W-1:0]  prio_q [NUM_IRQ];
   logic [ID_W-1:0]    in_service_q;
   logic [ID_W-1:0]    win_id;
   logic [ID_W-1:0]    prio_sel;
   logic [9:0]         idx;
   logic [9:0]         prio_off;
   logic               access;
   logic               wr_stb;
   logic               rd_acc;
   logic               is_prio;
   logic               mapped;
   logic               claim_rd;
   logic               complete_wr;
   logic               complete_ok;
   logic               any_elig;
   logic [31:0]        rdata;
   logic               unused_bits;

   assign idx         = apb.paddr_i[11:2];
   assign access      = apb.psel_i & apb.penable_i;
   assign wr_stb      = access & apb.pwrite_i;
   assign rd_acc      = access & ~apb.pwrite_i;
   assign prio_off    = idx - IDX_PRIO;
   assign prio_sel    = prio_off[ID_W-1:0];
   assign is_prio     = (idx >= IDX_PRIO) && (idx < IDX_PRIO_END);
   assign mapped      = (idx <= IDX_EDGE) || is_prio;
   assign claim_rd    = rd_acc && (idx == IDX_CLAIM) && (state_q == ST_ASSERT);
   assign complete_wr = wr_stb && (idx == IDX_CLAIM);
   assign complete_ok = complete_wr && (state_q == ST_SERVICE) &&
                        (apb.pwdata_i[ID_W-1:0] == in_service_q);

   assign apb.pready_o  = 1'b1;
   assign apb.pslverr_o = access & (~mapped | (complete_wr & ~complete_ok));
   assign unused_bits   = ^{apb.paddr_i[31:12], apb.paddr_i[1:0], apb.pwdata_i, prio_off};

`ifdef IRQC_EDGE_MODE_EN
   logic [NUM_IRQ-1:0] edge_q;
   logic [NUM_IRQ-1:0] trig_q;

   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         edge_q <= '0;
         trig_q <= '0;
      end else begin
         trig_q <= irq_trigger_i;
         if (wr_stb && (idx == IDX_EDGE)) edge_q <= apb.pwdata_i[NUM_IRQ-1:0];
      end
   end

   assign set_src = (irq_trigger_i & ~edge_q) | (irq_trigger_i & ~trig_q & edge_q);
   assign edge_rd = edge_q;
`else
   assign set_src = irq_trigger_i;
   assign edge_rd = '0;
`endif

   always_comb begin
      rdata = '0;
      if (rd_acc) begin
         case (idx)
            IDX_ENABLE:  rdata[NUM_IRQ-1:0] = enable_q;
            IDX_PENDING: rdata[NUM_IRQ-1:0] = pending_q;
            IDX_THRESH:  rdata[PRIO_W-1:0]  = thresh_q;
            IDX_CLAIM: begin
               if (state_q == ST_ASSERT) begin
                  rdata[31]         = 1'b1;
                  rdata[ID_W-1:0]   = irq_id_o;
               end
            end
            IDX_EDGE:    rdata[NUM_IRQ-1:0] = edge_rd;
            default: begin
               if (is_prio) rdata[PRIO_W-1:0] = prio_q[prio_sel];
            end
         endcase
      end
   end

   assign apb.prdata_o = rdata;

   // Descending scan with >= lets the lower index win a priority tie.
   always_comb begin
      eligible = '0;
      win_id   = '0;
      win_prio = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         eligible[i] = pending_q[i] & enable_q[i] & (prio_q[i] > thresh_q);
         if (eligible[i] && (prio_q[i] >= win_prio)) begin
            win_id   = ID_W'(i);
            win_prio = prio_q[i];
         end
      end
   end

   assign any_elig = |eligible;

   always_comb begin
      claim_clr = '0;
      if (claim_rd) claim_clr[irq_id_o] = 1'b1;
      pending_d = pending_q;
      if (wr_stb && (idx == IDX_PENDING)) pending_d = pending_d & ~apb.pwdata_i[NUM_IRQ-1:0];
      pending_d = pending_d & ~claim_clr;
      if (enable_i) pending_d = pending_d | set_src;
   end

   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         enable_q  <= '0;
         thresh_q  <= '0;
         pending_q <= '0;
         for (int i = 0; i < NUM_IRQ; i++) prio_q[i] <= '0;
      end else begin
         pending_q <= pending_d;
         if (wr_stb) begin
            if (idx == IDX_ENABLE) enable_q <= apb.pwdata_i[NUM_IRQ-1:0];
            if (idx == IDX_THRESH) thresh_q <= apb.pwdata_i[PRIO_W-1:0];
            if (is_prio) prio_q[prio_sel] <= apb.pwdata_i[PRIO_W-1:0];
         end
      end
   end

   // Claim and complete are bus-driven and proceed even while enable_i is low.
   always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         interrupt_o  <= 1'b0;
         irq_id_o     <= '0;
         in_service_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable_i && any_elig) begin
                  state_q     <= ST_ASSERT;
                  interrupt_o <= 1'b1;
                  irq_id_o    <= win_id;
               end
            end
            ST_ASSERT: begin
               if (claim_rd) begin
                  state_q      <= ST_SERVICE;
                  interrupt_o  <= 1'b0;
                  in_service_q <= irq_id_o;
               end else if (enable_i) begin
                  if (any_elig) begin
                     irq_id_o <= win_id;
                  end else begin
                     state_q     <= ST_IDLE;
                     interrupt_o <= 1'b0;
                  end
               end
            end
            ST_SERVICE: begin
               if (complete_ok) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl_prio_apb.sv
// Self-checking bench for irq_ctrl_prio_apb: expected values queued at stimulus time,
// popped and compared when the DUT output is sampled.
module tb_irq_ctrl_prio_apb;
   localparam int NUM_IRQ = 8;
   localparam int PRIO_W  = 3;
   localparam int ID_W    = 3;

   logic               clk    = 1'b0;
   logic               rst_n  = 1'b0;
   logic               enable = 1'b0;
   logic [NUM_IRQ-1:0] trig   = '0;
   logic               intr;
   logic [ID_W-1:0]    id;

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp;
   logic [31:0] rd;
   logic        err;

   irq_ctrl_prio_apb_if apb_if();

   irq_ctrl_prio_apb #(.NUM_IRQ(NUM_IRQ), .PRIO_W(PRIO_W)) dut (
      .pclk_i       (clk),
      .rst_n_i      (rst_n),
      .enable_i     (enable),
      .apb          (apb_if),
      .irq_trigger_i(trig),
      .interrupt_o  (intr),
      .irq_id_o     (id)
   );

   always #5 clk = ~clk;

   // Returns one cycle after the access edge; rdata/slverr sampled mid access phase.
   task automatic apb_acc(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic slverr);
      @(posedge clk); #1;
      apb_if.psel_i = 1'b1; apb_if.penable_i = 1'b0; apb_if.pwrite_i = wr;
      apb_if.paddr_i = addr; apb_if.pwdata_i = wdata;
      @(posedge clk); #1;
      apb_if.penable_i = 1'b1;
      #3;
      rdata  = apb_if.prdata_o;
      slverr = apb_if.pslverr_o;
      @(posedge clk); #1;
      apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [31:0] addrs[$];
      addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
      for (int i = 0; i < NUM_IRQ; i++) addrs.push_back(32'h20 + 32'(4 * i));
      exp_q.push_back({28'd0, 1'b0, 3'd0});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL reset_irq: got %h want %h", {intr, id}, exp); end
      foreach (addrs[k]) begin
         exp_q.push_back(32'h0);
         apb_acc(1'b0, addrs[k], 32'h0, rd, err);
         n_chk++; exp = exp_q.pop_front();
         if (rd !== exp) begin n_err++; $display("FAIL reset_reg_%h: got %h want %h", addrs[k], rd, exp); end
         n_chk++;
         if (err !== 1'b0) begin n_err++; $display("FAIL reset_err_%h: got %b want 0", addrs[k], err); end
      end
   endtask

   task automatic test_tie_claim;
      apb_acc(1'b1, 32'h28, 32'd3, rd, err);
      apb_acc(1'b1, 32'h34, 32'd3, rd, err);
      apb_acc(1'b1, 32'h00, 32'h24, rd, err);
      apb_acc(1'b1, 32'h08, 32'd1, rd, err);
      trig = 8'h20; cyc(1);
      trig = 8'h04; cyc(1);
      trig = 8'h00;
      exp_q.push_back({28'd0, 1'b1, 3'd5});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL first_assert: got %h want %h", {intr, id}, exp); end
      cyc(1);
      exp_q.push_back({28'd0, 1'b1, 3'd2});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL tie_lowest: got %h want %h", {intr, id}, exp); end
      exp_q.push_back(32'h8000_0002);
      apb_acc(1'b0, 32'h0C, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL claim_2: got %h want %h", rd, exp); end
      exp_q.push_back({28'd0, 1'b0, 3'd2});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL claim_drop: got %h want %h", {intr, id}, exp); end
      exp_q.push_back(32'h20);
      apb_acc(1'b0, 32'h04, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL pend_after_claim: got %h want %h", rd, exp); end
      apb_acc(1'b1, 32'h0C, 32'd2, rd, err);
      n_chk++;
      if (err !== 1'b0) begin n_err++; $display("FAIL complete_2_err: got %b want 0", err); end
      cyc(1);
      exp_q.push_back({28'd0, 1'b1, 3'd5});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL reassert_5: got %h want %h", {intr, id}, exp); end
      exp_q.push_back(32'h8000_0005);
      apb_acc(1'b0, 32'h0C, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL claim_5: got %h want %h", rd, exp); end
      apb_acc(1'b1, 32'h0C, 32'd5, rd, err);
      apb_acc(1'b1, 32'h00, 32'h00, rd, err);
   endtask

   task automatic test_threshold;
      apb_acc(1'b1, 32'h24, 32'd2, rd, err);
      apb_acc(1'b1, 32'h00, 32'h02, rd, err);
      apb_acc(1'b1, 32'h08, 32'd2, rd, err);
      trig = 8'h02; cyc(3);
      exp_q.push_back(32'd0);
      n_chk++; exp = exp_q.pop_front();
      if (32'(intr) !== exp) begin n_err++; $display("FAIL thr_gate: got %b want %h", intr, exp); end
      apb_acc(1'b1, 32'h08, 32'd1, rd, err);
      exp_q.push_back(32'd0);
      n_chk++; exp = exp_q.pop_front();
      if (32'(intr) !== exp) begin n_err++; $display("FAIL thr_lower_early: got %b want %h", intr, exp); end
      cyc(1);
      exp_q.push_back({28'd0, 1'b1, 3'd1});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL thr_lower: got %h want %h", {intr, id}, exp); end
      apb_acc(1'b1, 32'h08, 32'd3, rd, err);
      exp_q.push_back(32'd1);
      n_chk++; exp = exp_q.pop_front();
      if (32'(intr) !== exp) begin n_err++; $display("FAIL thr_raise_early: got %b want %h", intr, exp); end
      cyc(1);
      exp_q.push_back(32'd0);
      n_chk++; exp = exp_q.pop_front();
      if (32'(intr) !== exp) begin n_err++; $display("FAIL thr_raise: got %b want %h", intr, exp); end
      trig = 8'h00;
      exp_q.push_back(32'h02);
      apb_acc(1'b0, 32'h04, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL thr_pending: got %h want %h", rd, exp); end
      apb_acc(1'b1, 32'h04, 32'h02, rd, err);
      exp_q.push_back(32'h00);
      apb_acc(1'b0, 32'h04, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL w1c: got %h want %h", rd, exp); end
      apb_acc(1'b1, 32'h08, 32'd0, rd, err);
   endtask

   task automatic test_service_errors;
      apb_acc(1'b1, 32'h30, 32'd5, rd, err);
      apb_acc(1'b1, 32'h00, 32'h10, rd, err);
      trig = 8'h10; cyc(1);
      trig = 8'h00; cyc(1);
      exp_q.push_back({28'd0, 1'b1, 3'd4});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL svc_assert: got %h want %h", {intr, id}, exp); end
      exp_q.push_back(32'h8000_0004);
      apb_acc(1'b0, 32'h0C, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL claim_4: got %h want %h", rd, exp); end
      apb_acc(1'b1, 32'h0C, 32'd3, rd, err);
      n_chk++;
      if (err !== 1'b1) begin n_err++; $display("FAIL complete_mismatch_err: got %b want 1", err); end
      exp_q.push_back(32'h0);
      apb_acc(1'b0, 32'h0C, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL claim_in_service: got %h want %h", rd, exp); end
      n_chk++;
      if (err !== 1'b0) begin n_err++; $display("FAIL claim_in_service_err: got %b want 0", err); end
      apb_acc(1'b0, 32'h0FC, 32'h0, rd, err);
      n_chk++;
      if (err !== 1'b1) begin n_err++; $display("FAIL unmapped_err: got %b want 1", err); end
      apb_acc(1'b1, 32'h10, 32'h0, rd, err);
      n_chk++;
      if (err !== 1'b0) begin n_err++; $display("FAIL edge_wr_err: got %b want 0", err); end
      trig = 8'h10; cyc(1);
      trig = 8'h00; cyc(2);
      exp_q.push_back(32'd0);
      n_chk++; exp = exp_q.pop_front();
      if (32'(intr) !== exp) begin n_err++; $display("FAIL svc_hold_low: got %b want %h", intr, exp); end
      exp_q.push_back(32'h10);
      apb_acc(1'b0, 32'h04, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL svc_accumulate: got %h want %h", rd, exp); end
      apb_acc(1'b1, 32'h0C, 32'd4, rd, err);
      n_chk++;
      if (err !== 1'b0) begin n_err++; $display("FAIL complete_4_err: got %b want 0", err); end
      cyc(1);
      exp_q.push_back({28'd0, 1'b1, 3'd4});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL svc_reassert: got %h want %h", {intr, id}, exp); end
      apb_acc(1'b0, 32'h0C, 32'h0, rd, err);
      apb_acc(1'b1, 32'h0C, 32'd4, rd, err);
      apb_acc(1'b1, 32'h0C, 32'd4, rd, err);
      n_chk++;
      if (err !== 1'b1) begin n_err++; $display("FAIL complete_idle_err: got %b want 1", err); end
      apb_acc(1'b1, 32'h00, 32'h00, rd, err);
   endtask

   task automatic test_level_hold;
      apb_acc(1'b1, 32'h20, 32'd1, rd, err);
      apb_acc(1'b1, 32'h00, 32'h01, rd, err);
`ifdef IRQC_EDGE_MODE_EN
      apb_acc(1'b1, 32'h10, 32'h01, rd, err);
`endif
      trig = 8'h01; cyc(2);
      exp_q.push_back({28'd0, 1'b1, 3'd0});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL hold_assert: got %h want %h", {intr, id}, exp); end
      exp_q.push_back(32'h8000_0000);
      apb_acc(1'b0, 32'h0C, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL claim_0: got %h want %h", rd, exp); end
`ifdef IRQC_EDGE_MODE_EN
      exp_q.push_back(32'h00);
`else
      exp_q.push_back(32'h01);
`endif
      apb_acc(1'b0, 32'h04, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL hold_pending: got %h want %h", rd, exp); end
      apb_acc(1'b1, 32'h0C, 32'd0, rd, err);
      cyc(1);
`ifdef IRQC_EDGE_MODE_EN
      exp_q.push_back(32'd0);
      n_chk++; exp = exp_q.pop_front();
      if (32'(intr) !== exp) begin n_err++; $display("FAIL edge_no_reassert: got %b want %h", intr, exp); end
      trig = 8'h00; cyc(1);
      trig = 8'h01; cyc(2);
`endif
      exp_q.push_back({28'd0, 1'b1, 3'd0});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL hold_reassert: got %h want %h", {intr, id}, exp); end
      trig = 8'h00; cyc(1);
      apb_acc(1'b0, 32'h0C, 32'h0, rd, err);
      apb_acc(1'b1, 32'h0C, 32'd0, rd, err);
      exp_q.push_back(32'h00);
      apb_acc(1'b0, 32'h04, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL hold_cleanup: got %h want %h", rd, exp); end
      apb_acc(1'b1, 32'h00, 32'h00, rd, err);
   endtask

   task automatic test_enable_reset;
      apb_acc(1'b1, 32'h38, 32'd4, rd, err);
      apb_acc(1'b1, 32'h00, 32'h40, rd, err);
      enable = 1'b0;
      trig = 8'h40; cyc(2);
      trig = 8'h00; cyc(1);
      exp_q.push_back(32'h00);
      apb_acc(1'b0, 32'h04, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL dis_pending: got %h want %h", rd, exp); end
      exp_q.push_back(32'd0);
      n_chk++; exp = exp_q.pop_front();
      if (32'(intr) !== exp) begin n_err++; $display("FAIL dis_irq: got %b want %h", intr, exp); end
      enable = 1'b1;
      trig = 8'h40; cyc(1);
      trig = 8'h00; cyc(1);
      exp_q.push_back({28'd0, 1'b1, 3'd6});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL en_assert_6: got %h want %h", {intr, id}, exp); end
      enable = 1'b0;
      apb_acc(1'b1, 32'h08, 32'd7, rd, err);
      cyc(2);
      exp_q.push_back({28'd0, 1'b1, 3'd6});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL freeze: got %h want %h", {intr, id}, exp); end
      enable = 1'b1; cyc(1);
      exp_q.push_back(32'd0);
      n_chk++; exp = exp_q.pop_front();
      if (32'(intr) !== exp) begin n_err++; $display("FAIL unfreeze_drop: got %b want %h", intr, exp); end
      apb_acc(1'b1, 32'h08, 32'd0, rd, err);
      cyc(1);
      exp_q.push_back({28'd0, 1'b1, 3'd6});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL pre_reset_assert: got %h want %h", {intr, id}, exp); end
      #2; rst_n = 1'b0; #1;
      exp_q.push_back({28'd0, 1'b0, 3'd0});
      n_chk++; exp = exp_q.pop_front();
      if ({28'd0, intr, id} !== exp) begin n_err++; $display("FAIL async_reset: got %h want %h", {intr, id}, exp); end
      cyc(1); rst_n = 1'b1;
      exp_q.push_back(32'h0);
      apb_acc(1'b0, 32'h38, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL reset_prio6: got %h want %h", rd, exp); end
      exp_q.push_back(32'h0);
      apb_acc(1'b0, 32'h04, 32'h0, rd, err);
      n_chk++; exp = exp_q.pop_front();
      if (rd !== exp) begin n_err++; $display("FAIL reset_pending: got %h want %h", rd, exp); end
   endtask

   initial begin
      apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b0;
      apb_if.paddr_i = '0; apb_if.pwdata_i = '0;
      cyc(2);
      rst_n  = 1'b1;
      enable = 1'b1;
      test_reset;
      test_tie_claim;
      test_threshold;
      test_service_errors;
      test_level_hold;
      test_enable_reset;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got still running want finished");
      $fatal(1, "timeout");
   end
endmodule
